pace_gen: RTL and testbench
===========================

PACE_GEN -- requirements
Module: pace_gen

Interface
REQ-001 SHALL have parameter PRESCALE, default 25000, meaning clk cycles per 1 ms strobe (range 2..65535).
REQ-002 SHALL have parameter BASE_MS, default 250, meaning phase half-period in ms at level 0 (range 1..255).
REQ-003 SHALL have parameter STEP_MS, default 16, meaning half-period reduction per level.
REQ-004 SHALL have parameter MAX_LEVEL, default 12, meaning saturating level limit; BASE_MS-MAX_LEVEL*STEP_MS SHALL be >=1.
REQ-005 SHALL have parameter APPLES_PER_LEVEL, default 4, meaning eat pulses needed per level-up (range 1..15).
REQ-006 SHALL have one clock and an asynchronous active-low reset: clk  in  1  rising-edge clock.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 i_restart  in  1  synchronous game restart, level-sensitive.
REQ-009 i_eat  in  1  one-cycle pulse per apple eaten.
REQ-010 i_failure  in  1  sticky game-over level.
REQ-011 i_success  in  1  sticky game-won level.
REQ-012 o_phase  out  1  game-speed phase; each toggle requests one game tick.
REQ-013 o_level  out  4  current speed level, 0..MAX_LEVEL.
REQ-014 o_score  out  8  apples eaten since restart, saturating at 255.
REQ-015 o_running  out  1  high while in RUN state.

Function
REQ-016 SHALL generate a one-cycle ms strobe every PRESCALE clk cycles from a free-running prescaler.
REQ-017 SHALL compute half-period P = BASE_MS - o_level*STEP_MS combinationally, 8-bit unsigned.
REQ-018 SHALL count ms strobes in an 8-bit interval counter; on a strobe with counter >= P-1, toggle o_phase and clear the counter, else increment.
REQ-019 SHALL use >= compare so a level-up that shortens P mid-interval toggles on the next strobe; no wrap-around.
REQ-020 SHALL have states RUN and HALT; RUN->HALT when i_failure|i_success is high; HALT->RUN only on i_restart.
REQ-021 In HALT SHALL freeze o_phase, interval counter, o_level and o_score; prescaler keeps running.
REQ-022 On i_eat in RUN SHALL increment o_score (saturating 255) and a 4-bit apple counter; when apple counter reaches APPLES_PER_LEVEL-1 it clears and o_level increments, saturating at MAX_LEVEL.
REQ-023 i_eat in the same cycle as RUN->HALT SHALL still be counted.
REQ-024 i_eat coinciding with a phase toggle SHALL take both actions; new P applies from the next interval compare.
REQ-025 i_restart SHALL have priority over all events: clear o_level, o_score, apple counter, interval counter, enter RUN next cycle; o_phase SHALL NOT change (receiver re-latches phase on restart).
REQ-026 o_running SHALL equal (state==RUN), registered.

Reset
REQ-027 On rst_n low SHALL asynchronously set: o_phase=0, o_level=0, o_score=0, o_running=1 (state RUN), prescaler=0, interval counter=0, apple counter=0.
REQ-028 First ms strobe after reset release SHALL occur PRESCALE cycles after the first active clk edge.

Structure
REQ-029 Constants BASE_MS, STEP_MS, MAX_LEVEL, APPLES_PER_LEVEL defaults and the RUN/HALT state enum SHALL live in shared package pace_pkg.
REQ-030 The prescaler SHALL be a sub-module ms_strobe (ports clk, rst_n, o_strobe).
REQ-031 All outputs SHALL be registered; no combinational input-to-output path.

Verification (PRESCALE=4, BASE_MS=5, STEP_MS=1, MAX_LEVEL=3, APPLES_PER_LEVEL=2)
REQ-032 Reset release, idle inputs -> o_phase toggles every 20 clk, o_level=0, o_score=0, o_running=1.
REQ-033 Six i_eat pulses spaced 3 clk -> o_score=6, o_level=3 (saturated), toggle spacing 8 clk.
REQ-034 i_failure high mid-interval -> o_running=0 next cycle, o_phase constant for 200 clk; i_restart -> counters zero, o_phase unchanged, toggles resume after 20 clk.
REQ-035 i_eat and i_success same cycle -> o_score incremented by 1, then HALT.
REQ-036 300 i_eat pulses -> o_score=255, no wrap; i_eat and i_restart same cycle -> o_score=0.
REQ-037 rst_n asserted mid-interval asynchronously -> all outputs at reset values before next clk edge.

Source files
------------

// File: rtl/pace_pkg.sv
// Shared constants and state encoding for the game pace generator.
// Imported by pace_gen and its prescaler.
package pace_pkg;

    localparam int PRESCALE_DEF = 25000;
    localparam int BASE_MS_DEF  = 250;
    localparam int STEP_MS_DEF  = 16;
    localparam int MAX_LVL_DEF  = 12;
    localparam int APPLES_DEF   = 4;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/pace_gen_ms_strobe.sv
// Free-running prescaler producing a registered one-cycle ms strobe.
// Keeps counting regardless of game state.
module ms_strobe
    import pace_pkg::*;
#(
    parameter int PRESCALE = PRESCALE_DEF
) (
    input  logic clk,
    input  logic rst_n,
    output logic o_strobe
);

    localparam logic [15:0] LAST = 16'(PRESCALE - 1);

    logic [15:0] cnt;

    // wrap the prescaler and flag the wrap one cycle later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            o_strobe <= 1'b0;
        end else begin
            cnt      <= (cnt == LAST) ? '0 : cnt + 16'd1;
            o_strobe <= (cnt == LAST);
        end
    end

endmodule

// File: rtl/pace_gen.sv
// Game pace generator: ms-based phase toggling whose half-period
// shrinks as apples are eaten; halts on game end until restart.
module pace_gen
    import pace_pkg::*;
#(
    parameter int PRESCALE         = PRESCALE_DEF,
    parameter int BASE_MS          = BASE_MS_DEF,
    parameter int STEP_MS          = STEP_MS_DEF,
    parameter int MAX_LEVEL        = MAX_LVL_DEF,
    parameter int APPLES_PER_LEVEL = APPLES_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_restart,
    input  logic       i_eat,
    input  logic       i_failure,
    input  logic       i_success,
    output logic       o_phase,
    output logic [3:0] o_level,
    output logic [7:0] o_score,
    output logic       o_running
);

    localparam logic [3:0] LVL_MAX  = 4'(MAX_LEVEL);
    localparam logic [3:0] APL_LAST = 4'(APPLES_PER_LEVEL - 1);

    state_t     state;
    logic       strobe;
    logic       run;
    logic [7:0] ivl;
    logic [3:0] apples;
    logic [7:0] half_p;
    logic [7:0] half_m1;

    ms_strobe #(
        .PRESCALE(PRESCALE)
    ) u_ms (
        .clk     (clk),
        .rst_n   (rst_n),
        .o_strobe(strobe)
    );

    assign run = (state == ST_RUN);

    // current half-period in ms and its last-count threshold
    always_comb begin
        half_p  = 8'(BASE_MS) - 8'(int'(o_level) * STEP_MS);
        half_m1 = half_p - 8'd1;
    end

    // run/halt control; o_running mirrors the state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            o_running <= 1'b1;
        end else if (i_restart) begin
            state     <= ST_RUN;
            o_running <= 1'b1;
        end else if (run && (i_failure || i_success)) begin
            state     <= ST_HALT;
            o_running <= 1'b0;
        end
    end

    // interval counting; >= lets a shortened period fire at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ivl     <= '0;
            o_phase <= 1'b0;
        end else if (i_restart) begin
            ivl <= '0;
        end else if (run && strobe) begin
            if (ivl >= half_m1) begin
                ivl     <= '0;
                o_phase <= ~o_phase;
            end else begin
                ivl <= ivl + 8'd1;
            end
        end
    end

    // score, apple count and speed level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_score <= '0;
            o_level <= '0;
            apples  <= '0;
        end else if (i_restart) begin
            o_score <= '0;
            o_level <= '0;
            apples  <= '0;
        end else if (run && i_eat) begin
            o_score <= sat_inc8(o_score);
            if (apples == APL_LAST) begin
                apples <= '0;
                if (o_level != LVL_MAX)
                    o_level <= o_level + 4'd1;
            end else begin
                apples <= apples + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_pace_gen.sv
// Directed self-checking bench for pace_gen with small parameters.
// Expected values are hand-computed from the intended behaviour.
module tb_pace_gen;

    logic       clk;
    logic       rst_n;
    logic       i_restart;
    logic       i_eat;
    logic       i_failure;
    logic       i_success;
    logic       o_phase;
    logic [3:0] o_level;
    logic [7:0] o_score;
    logic       o_running;

    int cyc = 0;
    int n_chk = 0;
    int n_err = 0;

    pace_gen #(
        .PRESCALE        (4),
        .BASE_MS         (5),
        .STEP_MS         (1),
        .MAX_LEVEL       (3),
        .APPLES_PER_LEVEL(2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_restart(i_restart),
        .i_eat    (i_eat),
        .i_failure(i_failure),
        .i_success(i_success),
        .o_phase  (o_phase),
        .o_level  (o_level),
        .o_score  (o_score),
        .o_running(o_running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_toggle(output int at);
        logic p0;
        p0 = o_phase;
        at = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (o_phase !== p0) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) chk("toggle_timeout", 0, 1);
    endtask

    task automatic pulse_eat();
        i_eat = 1'b1;
        step();
        i_eat = 1'b0;
    endtask

    initial begin
        int t0, t1, t2, rc, chg;
        logic ph;
        rst_n     = 1'b0;
        i_restart = 1'b0;
        i_eat     = 1'b0;
        i_failure = 1'b0;
        i_success = 1'b0;
        repeat (2) step();
        chk("rst_phase", int'(o_phase), 0);
        chk("rst_level", int'(o_level), 0);
        chk("rst_score", int'(o_score), 0);
        chk("rst_running", int'(o_running), 1);
        rst_n = 1'b1;

        // idle: half-period 5 ms * 4 clk
        wait_toggle(t0);
        wait_toggle(t1);
        wait_toggle(t2);
        chk("idle_gap1", t1 - t0, 20);
        chk("idle_gap2", t2 - t1, 20);
        chk("idle_level", int'(o_level), 0);
        chk("idle_score", int'(o_score), 0);
        chk("idle_running", int'(o_running), 1);

        // six apples -> level saturates at 3, P = 2 ms
        step();
        for (int i = 0; i < 6; i++) begin
            pulse_eat();
            step();
            step();
        end
        chk("eat6_score", int'(o_score), 6);
        chk("eat6_level", int'(o_level), 3);
        wait_toggle(t0);
        wait_toggle(t1);
        wait_toggle(t2);
        chk("fast_gap1", t1 - t0, 8);
        chk("fast_gap2", t2 - t1, 8);

        // failure mid-interval freezes everything
        step();
        step();
        i_failure = 1'b1;
        step();
        @(negedge clk);
        chk("fail_running", int'(o_running), 0);
        ph = o_phase;
        step();
        pulse_eat();
        chk("halt_score", int'(o_score), 6);
        chk("halt_level", int'(o_level), 3);
        chg = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (o_phase !== ph) chg++;
        end
        chk("halt_phase_chg", chg, 0);

        // restart clears counters but keeps phase
        step();
        i_failure = 1'b0;
        i_restart = 1'b1;
        step();
        rc = cyc;
        i_restart = 1'b0;
        @(negedge clk);
        chk("rs_level", int'(o_level), 0);
        chk("rs_score", int'(o_score), 0);
        chk("rs_running", int'(o_running), 1);
        chk("rs_phase", int'(o_phase), int'(ph));
        wait_toggle(t0);
        chk("rs_first", int'((t0 - rc) >= 17 && (t0 - rc) <= 20), 1);
        wait_toggle(t1);
        chk("rs_gap", t1 - t0, 20);

        // eat together with success is counted, then halt
        step();
        i_eat     = 1'b1;
        i_success = 1'b1;
        step();
        i_eat = 1'b0;
        @(negedge clk);
        chk("win_score", int'(o_score), 1);
        chk("win_running", int'(o_running), 0);
        step();
        pulse_eat();
        chk("win_halt_score", int'(o_score), 1);
        i_success = 1'b0;
        i_restart = 1'b1;
        step();
        i_restart = 1'b0;
        @(negedge clk);
        chk("win_rs_score", int'(o_score), 0);
        chk("win_rs_running", int'(o_running), 1);

        // 300 apples saturate the score
        step();
        i_eat = 1'b1;
        repeat (300) step();
        i_eat = 1'b0;
        @(negedge clk);
        chk("sat_score", int'(o_score), 255);
        chk("sat_level", int'(o_level), 3);
        step();
        i_eat     = 1'b1;
        i_restart = 1'b1;
        step();
        i_eat     = 1'b0;
        i_restart = 1'b0;
        @(negedge clk);
        chk("eat_rs_score", int'(o_score), 0);
        chk("eat_rs_level", int'(o_level), 0);

        // async reset mid-interval
        step();
        for (int i = 0; i < 3; i++) pulse_eat();
        chk("pre_score", int'(o_score), 3);
        chk("pre_level", int'(o_level), 1);
        for (int i = 0; i < 2 && o_phase !== 1'b1; i++) wait_toggle(t0);
        chk("pre_phase", int'(o_phase), 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_phase", int'(o_phase), 0);
        chk("arst_level", int'(o_level), 0);
        chk("arst_score", int'(o_score), 0);
        chk("arst_running", int'(o_running), 1);
        step();
        rst_n = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
